// File: rtl/mrc_std_lane_buffer.sv
// Per-lane FWFT FIFOs between the MRC and downstream, with optional lockstep
// (aligned) release across enabled lanes and per-lane message framing checks.
module mrc_std_lane_buffer #(
    parameter int NUM_LANES = 32,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_poweron,
    input  logic                          cfg_align_mode,
    input  logic [NUM_LANES-1:0]          cfg_lane_enable,
    input  logic [NUM_LANES-1:0]          mrc__std__lane_valid,
    input  logic [2*NUM_LANES-1:0]        mrc__std__lane_cntl,
    input  logic [DATA_W*NUM_LANES-1:0]   mrc__std__lane_data,
    output logic [NUM_LANES-1:0]          std__mrc__lane_ready,
    output logic [NUM_LANES-1:0]          std__dn__lane_valid,
    output logic [2*NUM_LANES-1:0]        std__dn__lane_cntl,
    output logic [DATA_W*NUM_LANES-1:0]   std__dn__lane_data,
    input  logic [NUM_LANES-1:0]          dn__std__lane_ready,
    output logic [NUM_LANES-1:0]          framing_err,
    input  logic                          err_clear,
    output logic                          active_mode
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_W + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_MSG = 1'b1
    } frm_state_t;

    logic                 r_run;
    logic                 r_active_mode;
    logic [NUM_LANES-1:0] r_err;

    logic [NUM_LANES-1:0] w_nonempty;
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_ready;
    logic [NUM_LANES-1:0] w_push;
    logic [NUM_LANES-1:0] w_valid;
    logic [NUM_LANES-1:0] w_pop;
    logic [NUM_LANES-1:0] w_err_set;
    logic                 w_all_nonempty;
    logic                 w_align_pop;
    logic                 w_all_empty;

    // Ready is held low until the first edge after reset release.
    always_comb begin
        w_ready = {NUM_LANES{r_run}} & cfg_lane_enable & ~w_full;
        w_push  = mrc__std__lane_valid & w_ready;
    end

    // Aligned release needs every enabled lane non-empty and every enabled lane ready.
    always_comb begin
        w_all_nonempty = (&(w_nonempty | ~cfg_lane_enable)) & (|cfg_lane_enable);
        w_align_pop    = w_all_nonempty & (&(dn__std__lane_ready | ~cfg_lane_enable));
        w_valid        = cfg_lane_enable & w_nonempty;
        w_pop          = w_valid & dn__std__lane_ready;
        if (r_active_mode) begin
            w_valid = cfg_lane_enable & {NUM_LANES{w_all_nonempty}};
            w_pop   = cfg_lane_enable & {NUM_LANES{w_align_pop}};
        end
        w_all_empty = ~|w_nonempty;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_run         <= 1'b0;
            r_active_mode <= 1'b0;
            r_err         <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_all_empty) begin
                r_active_mode <= cfg_align_mode;
            end
            r_err <= w_err_set | (r_err & ~{NUM_LANES{err_clear}});
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [EW-1:0] r_mem [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic [CW-1:0] r_count;
        frm_state_t    r_state;
        frm_state_t    w_state_nxt;
        logic          w_err;
        logic [1:0]    w_in_cntl;
        logic [EW-1:0] w_head;

        assign w_in_cntl = mrc__std__lane_cntl[2*i +: 2];
        assign w_head    = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                r_mem[r_wr_ptr] <= {w_in_cntl, mrc__std__lane_data[DATA_W*i +: DATA_W]};
            end
        end

        // Pointers wrap naturally since DEPTH is a power of two.
        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // The next state is always the one the cntl implies; cntl[0] marks a start,
        // cntl[1] an end, so a start seen mid-message or a non-start seen idle is an error.
        always_comb begin
            w_state_nxt = r_state;
            w_err       = 1'b0;
            if (w_push[i]) begin
                w_state_nxt = w_in_cntl[1] ? ST_IDLE : ST_IN_MSG;
                w_err       = (r_state == ST_IN_MSG) ? w_in_cntl[0] : ~w_in_cntl[0];
            end
        end

        assign w_nonempty[i] = (r_count != '0);
        assign w_full[i]     = (r_count == FULL_CNT);
        assign w_err_set[i]  = w_err;

        assign std__dn__lane_cntl[2*i +: 2]         = w_nonempty[i] ? w_head[DATA_W +: 2] : 2'b00;
        assign std__dn__lane_data[DATA_W*i +: DATA_W] = w_nonempty[i] ? w_head[DATA_W-1:0] : '0;
    end

    assign std__mrc__lane_ready = w_ready;
    assign std__dn__lane_valid  = w_valid;
    assign framing_err          = r_err;
    assign active_mode          = r_active_mode;

endmodule

// File: tb/tb_mrc_std_lane_buffer.sv
// Directed bench for mrc_std_lane_buffer: stimulus pushes expected beats into
// per-lane queues; a negedge monitor pops and compares on every downstream transfer.
module tb_mrc_std_lane_buffer;

    localparam int NL = 8;
    localparam int DW = 16;
    localparam int DP = 4;

    localparam logic [1:0] MOM     = 2'b00;
    localparam logic [1:0] SOM     = 2'b01;
    localparam logic [1:0] EOM     = 2'b10;
    localparam logic [1:0] SOM_EOM = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              cfg_align;
    logic [NL-1:0]     en;
    logic [NL-1:0]     in_valid;
    logic [2*NL-1:0]   in_cntl;
    logic [DW*NL-1:0]  in_data;
    logic [NL-1:0]     up_ready;
    logic [NL-1:0]     dn_valid;
    logic [2*NL-1:0]   dn_cntl;
    logic [DW*NL-1:0]  dn_data;
    logic [NL-1:0]     dn_ready;
    logic [NL-1:0]     ferr;
    logic              err_clear;
    logic              act_mode;

    logic [DW+1:0]     exp_q [NL][$];
    int                hs_cnt [NL];
    int                n_checks;
    int                n_err;
    logic              tb_align;
    logic              mon_pop_all;
    int                hs_base;
    int                leftover;

    mrc_std_lane_buffer #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk                  (clk),
        .reset_poweron        (rst_n),
        .cfg_align_mode       (cfg_align),
        .cfg_lane_enable      (en),
        .mrc__std__lane_valid (in_valid),
        .mrc__std__lane_cntl  (in_cntl),
        .mrc__std__lane_data  (in_data),
        .std__mrc__lane_ready (up_ready),
        .std__dn__lane_valid  (dn_valid),
        .std__dn__lane_cntl   (dn_cntl),
        .std__dn__lane_data   (dn_data),
        .dn__std__lane_ready  (dn_ready),
        .framing_err          (ferr),
        .err_clear            (err_clear),
        .active_mode          (act_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ln, input logic [1:0] c, input logic [DW-1:0] d);
        in_valid[ln]        = 1'b1;
        in_cntl[2*ln +: 2]  = c;
        in_data[DW*ln +: DW] = d;
        exp_q[ln].push_back({c, d});
    endtask

    // Monitor: a transfer happens when the bench-modelled pop condition holds.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_pop_all = (&(dn_ready | ~en)) && (en != '0) && ((dn_valid & en) == en);
            for (int i = 0; i < NL; i++) begin
                if (tb_align ? (en[i] && mon_pop_all) : (dn_valid[i] && dn_ready[i])) begin
                    hs_cnt[i]++;
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL lane%0d_unexpected: got %0h expected none", i,
                                 {dn_cntl[2*i +: 2], dn_data[DW*i +: DW]});
                    end else begin
                        chk($sformatf("lane%0d_out", i),
                            {46'd0, dn_cntl[2*i +: 2], dn_data[DW*i +: DW]},
                            {46'd0, exp_q[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err = 0;
        tb_align = 1'b0;
        for (int i = 0; i < NL; i++) hs_cnt[i] = 0;
        rst_n = 1'b0;
        cfg_align = 1'b0;
        en = '1;
        in_valid = '0;
        in_cntl = '0;
        in_data = '0;
        dn_ready = '0;
        err_clear = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", up_ready, 0);
        chk("rst_valid", dn_valid, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_mode", act_mode, 0);
        chk("rst_data", dn_data, 0);
        chk("rst_cntl", dn_cntl, 0);
        rst_n = 1'b1;
        #2;
        chk("ready_before_edge", up_ready, 0);
        step();
        chk("ready_after_edge", up_ready, 8'hFF);

        // Lane 0 fills to DEPTH, fifth beat waits, then drains in order
        en = 8'h01;
        for (int k = 0; k < 4; k++) begin
            drive(0, (k == 0) ? SOM : MOM, 16'h0100 + 16'(k));
            step();
            if (k == 0) begin
                chk("fwft_valid", dn_valid, 8'h01);
                chk("fwft_data", dn_data[DW-1:0], 16'h0100);
            end
        end
        chk("ready_full", up_ready, 8'h00);
        chk("head_held", dn_data[DW-1:0], 16'h0100);
        drive(0, EOM, 16'h0104);
        dn_ready[0] = 1'b1;
        step();
        step();
        in_valid = '0;
        repeat (4) step();
        chk("lane0_drained", dn_valid, 0);
        chk("lane0_ferr", ferr, 0);

        // Continuous stream through lane 0: 20 beats, no bubbles, pointers wrap
        hs_base = hs_cnt[0];
        for (int k = 0; k < 20; k++) begin
            drive(0, (k == 0) ? SOM : ((k == 19) ? EOM : MOM), 16'(k));
            step();
            chk("stream_valid", dn_valid[0], 1);
        end
        in_valid = '0;
        step();
        chk("stream_no_bubble", hs_cnt[0] - hs_base, 20);
        chk("stream_empty", dn_valid, 0);

        // Framing errors on lane 5
        en = 8'hFF;
        dn_ready = '0;
        drive(5, MOM, 16'h5A5A);
        step();
        in_valid = '0;
        chk("err_mom_idle", ferr, 8'h20);
        chk("err_data_kept", dn_valid, 8'h20);
        chk("err_data_val", dn_data[DW*5 +: DW], 16'h5A5A);
        drive(5, SOM, 16'h5A5B);
        err_clear = 1'b1;
        dn_ready = 8'h20;
        step();
        in_valid = '0;
        chk("err_set_wins", ferr, 8'h20);
        step();
        chk("err_cleared", ferr, 0);
        err_clear = 1'b0;
        drive(5, EOM, 16'h5A5C);
        step();
        chk("eom_after_recover", ferr, 0);
        drive(5, SOM_EOM, 16'h5A5D);
        step();
        chk("som_eom_idle", ferr, 0);
        drive(5, EOM, 16'h5A5E);
        step();
        in_valid = '0;
        chk("eom_in_idle", ferr, 8'h20);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("err_clear2", ferr, 0);
        chk("lane5_drained", dn_valid, 0);

        // Align mode: lane 2 arrives three cycles late
        dn_ready = 8'hFF;
        cfg_align = 1'b1;
        en = 8'h0F;
        step();
        tb_align = 1'b1;
        chk("mode_align", act_mode, 1);
        drive(0, SOM_EOM, 16'h00A0);
        drive(1, SOM_EOM, 16'h00A1);
        drive(3, SOM_EOM, 16'h00A3);
        step();
        in_valid = '0;
        chk("align_wait0", dn_valid, 0);
        step();
        chk("align_wait1", dn_valid, 0);
        step();
        chk("align_wait2", dn_valid, 0);
        drive(2, SOM_EOM, 16'h00A2);
        step();
        in_valid = '0;
        chk("align_release", dn_valid, 8'h0F);
        step();
        chk("align_popped", dn_valid, 0);

        // Align mode: lane 1 stalls everyone
        dn_ready = 8'hFD;
        for (int i = 0; i < 4; i++) drive(i, SOM_EOM, 16'h00B0 + 16'(i));
        step();
        in_valid = '0;
        chk("stall_valid", dn_valid, 8'h0F);
        step();
        step();
        chk("stall_hold", dn_valid, 8'h0F);
        dn_ready = 8'hFF;
        step();
        chk("stall_release_once", dn_valid, 0);

        // Align with no lanes enabled; disabled lanes keep their data
        dn_ready = '0;
        for (int i = 0; i < 4; i++) drive(i, SOM_EOM, 16'h00C0 + 16'(i));
        step();
        in_valid = '0;
        en = '0;
        step();
        chk("align_none_enabled", dn_valid, 0);
        chk("disabled_ready", up_ready, 0);
        dn_ready = 8'hFF;
        step();
        chk("none_enabled_nopop", dn_valid, 0);
        en = 8'h0F;
        #1;
        chk("reenable_release", dn_valid, 8'h0F);
        step();
        chk("reenable_drained", dn_valid, 0);

        // Mode held while buffered, then reset discards the entries
        en = 8'h01;
        dn_ready = '0;
        drive(0, SOM, 16'h00D0);
        step();
        cfg_align = 1'b0;
        drive(0, MOM, 16'h00D1);
        step();
        drive(0, MOM, 16'h00D2);
        step();
        in_valid = '0;
        step();
        chk("mode_held", act_mode, 1);
        chk("buffered_valid", dn_valid, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", dn_valid, 0);
        chk("async_rst_data", dn_data, 0);
        chk("async_rst_cntl", dn_cntl, 0);
        chk("async_rst_ready", up_ready, 0);
        chk("async_rst_mode", act_mode, 0);
        for (int i = 0; i < NL; i++) exp_q[i].delete();
        tb_align = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_ready", up_ready, 8'h01);
        chk("no_stale", dn_valid, 0);

        // Mode change waits for all FIFOs to be empty
        en = 8'h03;
        drive(0, SOM_EOM, 16'h00E0);
        step();
        in_valid = '0;
        cfg_align = 1'b1;
        step();
        chk("mode_wait_empty", act_mode, 0);
        dn_ready = 8'h03;
        step();
        chk("mode_wait_pop", act_mode, 0);
        step();
        chk("mode_loaded_empty", act_mode, 1);
        tb_align = 1'b1;
        chk("final_ferr", ferr, 0);

        leftover = 0;
        for (int i = 0; i < NL; i++) leftover += exp_q[i].size();
        chk("leftover_expected", leftover, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
